decrypt_1block_128: RTL

Ascon-128 (v1.2) single-block authenticated decryptor, the receive-side counterpart of the one-block encryption top.
- Inputs: 128-bit key, 128-bit nonce, one full 64-bit associated-data block, one full 64-bit ciphertext block and the received 128-bit tag.
- Outputs: the recovered 64-bit plaintext and a tag-match flag.
- Iterative core: one permutation round per clock, sequenced by an FSM with a START/DONE handshake.

---
 rtl/decrypt_1block_128_pkg.sv | 21 ++
 rtl/decrypt_1block_128_round.sv | 38 +++
 rtl/decrypt_1block_128.sv | 110 +++++++++++
 3 files changed

// File: rtl/decrypt_1block_128_pkg.sv
// decrypt_1block_128_pkg: shared constants, FSM encoding and helpers for the Ascon-128 decryptor.
// Contents: IV, PAD, state_t, ror() rotate-right, rc_of() round constant.
package decrypt_1block_128_pkg;

    localparam logic [63:0] IV  = 64'h80400C0600000000;
    localparam logic [63:0] PAD = 64'h8000000000000000;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_AD, ST_ADP, ST_MSG, ST_FIN, ST_TAG, ST_DONE
    } state_t;

    function automatic logic [63:0] ror(input logic [63:0] x, input int sh);
        return (x >> sh) | (x << (64 - sh));
    endfunction

    // Constants F0, E1, ..., 4B are the round index in the low nibble and its complement above.
    function automatic logic [7:0] rc_of(input logic [3:0] r);
        return {~r, r};
    endfunction

endpackage

// File: rtl/decrypt_1block_128_round.sv
// decrypt_1block_128_round: one combinational Ascon permutation round.
// Ports: s_in[319:0] state in (S0 in the top word), rc[7:0] round constant, s_out[319:0] state out.
module decrypt_1block_128_round
    import decrypt_1block_128_pkg::*;
(
    input  logic [319:0] s_in,
    input  logic [7:0]   rc,
    output logic [319:0] s_out
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] y0, y1, y2, y3, y4;
    logic [63:0] z0, z1, z2, z3, z4;

    always_comb begin
        x0 = s_in[319:256] ^ s_in[63:0];
        x1 = s_in[255:192];
        x2 = s_in[191:128] ^ {56'h0, rc} ^ s_in[255:192];
        x3 = s_in[127:64];
        x4 = s_in[63:0] ^ s_in[127:64];
        y0 = x0 ^ (~x1 & x2);
        y1 = x1 ^ (~x2 & x3);
        y2 = x2 ^ (~x3 & x4);
        y3 = x3 ^ (~x4 & x0);
        y4 = x4 ^ (~x0 & x1);
        z0 = y0 ^ y4;
        z1 = y1 ^ y0;
        z2 = ~y2;
        z3 = y3 ^ y2;
        z4 = y4;
        s_out = {z0 ^ ror(z0, 19) ^ ror(z0, 28),
                 z1 ^ ror(z1, 61) ^ ror(z1, 39),
                 z2 ^ ror(z2, 1)  ^ ror(z2, 6),
                 z3 ^ ror(z3, 10) ^ ror(z3, 17),
                 z4 ^ ror(z4, 7)  ^ ror(z4, 41)};
    end

endmodule

// File: rtl/decrypt_1block_128.sv
// decrypt_1block_128: iterative Ascon-128 single-block authenticated decryptor, one round per clock.
// Ports: clk, rst_n (async active-low); start request with sk/n/a/c/t_in captured on acceptance;
// busy while running, done one-cycle pulse; p plaintext, t recomputed tag, valid tag match (held).
module decrypt_1block_128
    import decrypt_1block_128_pkg::*;
#(
    parameter bit ZERO_ON_FAIL = 1'b1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] sk,
    input  logic [127:0] n,
    input  logic [63:0]  a,
    input  logic [63:0]  c,
    input  logic [127:0] t_in,
    output logic         busy,
    output logic         done,
    output logic [63:0]  p,
    output logic [127:0] t,
    output logic         valid
);

    state_t       st;
    logic [3:0]   r;
    logic [319:0] s, rnd;
    logic [127:0] k_reg, ti_reg, tag;
    logic [63:0]  a_reg, c_reg, p_int;
    logic         last;

    decrypt_1block_128_round u_round (.s_in(s), .rc(rc_of(r)), .s_out(rnd));

    assign last = r == 4'd11;
    assign tag  = s[127:0] ^ k_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_IDLE;
            r      <= '0;
            s      <= '0;
            k_reg  <= '0;
            ti_reg <= '0;
            a_reg  <= '0;
            c_reg  <= '0;
            p_int  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
            t      <= '0;
            valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                // DONE accepts a new request just like IDLE, so busy never drops between runs.
                ST_IDLE, ST_DONE: begin
                    busy <= start;
                    st   <= start ? ST_INIT : ST_IDLE;
                    if (start) begin
                        s      <= {IV, sk, n};
                        k_reg  <= sk;
                        a_reg  <= a;
                        c_reg  <= c;
                        ti_reg <= t_in;
                        r      <= '0;
                    end
                end
                ST_TAG: begin
                    t     <= tag;
                    valid <= tag == ti_reg;
                    p     <= (ZERO_ON_FAIL && tag != ti_reg) ? '0 : p_int;
                    done  <= 1'b1;
                    st    <= ST_DONE;
                end
                default: begin
                    s <= rnd;
                    r <= r + 4'd1;
                    // Phase boundaries fold their absorb/key steps into the last round's write-back.
                    if (last) begin
                        r <= 4'd6;
                        case (st)
                            ST_INIT: begin
                                s  <= rnd ^ {a_reg, 128'h0, k_reg};
                                st <= ST_AD;
                            end
                            ST_AD: begin
                                s  <= rnd ^ {PAD, 256'h0};
                                st <= ST_ADP;
                            end
                            ST_ADP: begin
                                s     <= {c_reg, rnd[255:1], ~rnd[0]};
                                p_int <= rnd[319:256] ^ c_reg;
                                st    <= ST_MSG;
                            end
                            ST_MSG: begin
                                s  <= rnd ^ {PAD, k_reg, 128'h0};
                                r  <= '0;
                                st <= ST_FIN;
                            end
                            default: begin
                                r  <= r;
                                st <= ST_TAG;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
